obstacle_field: RTL

- Parametrised successor to the two-obstacle generator.
- Manages a pool of NUM_OBS obstacle slots that scroll left on a shared step tick.
- Spawns obstacles into free slots at LFSR-randomised gaps, lanes and types, and retires them at x=0.
- Tracks a difficulty level that shortens the step period as obstacles pass. Feeds the renderer and collision logic; game_state comes from the top-level game FSM.

---
 rtl/obstacle_field.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/obstacle_field.sv
// Pool of NUM_OBS scrolling obstacle slots with LFSR-driven spawning and a step prescaler.
// Define OBS_SPEEDUP_EN to enable difficulty levels; otherwise level=0 and the step period is BASE_PERIOD.
module obstacle_field #(
    parameter int          NUM_OBS     = 4,
    parameter int          X_W         = 10,
    parameter int          SPAWN_X     = 740,
    parameter int          BASE_PERIOD = 1023,
    parameter int          PERIOD_DEC  = 64,
    parameter int          MIN_PERIOD  = 255,
    parameter int          MIN_GAP     = 160,
    parameter int          GAP_RAND_W  = 7,
    parameter int          LEVEL_STEP  = 8,
    parameter int          MAX_LEVEL   = 7,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             game_state,
    output logic [NUM_OBS*X_W-1:0] obs_x,
    output logic [NUM_OBS*2-1:0]   obs_lane,
    output logic [NUM_OBS*2-1:0]   obs_type,
    output logic [NUM_OBS-1:0]     obs_active,
    output logic                   flick,
    output logic                   step,
    output logic [2:0]             level,
    output logic                   passed
);

    localparam logic [X_W-1:0] SPAWN_XV  = X_W'(SPAWN_X);
    localparam logic [15:0]    MIN_GAP16 = 16'(MIN_GAP);

    if (NUM_OBS < 1 || NUM_OBS > 8 || MAX_LEVEL > 7 || LEVEL_STEP < 1 ||
        MIN_PERIOD < 1 || PERIOD_DEC < 0 || LFSR_SEED == 16'h0) begin : g_bad_cfg
        $error("obstacle_field: invalid parameter set");
    end

    logic [15:0]        lfsr;
    logic [15:0]        tick_cnt, gap_cnt, gap_tgt, period;
    logic [15:0]        gap_inc, gap_n, tgt_n;
    logic [X_W-1:0]     x_q    [NUM_OBS];
    logic [X_W-1:0]     x_n    [NUM_OBS];
    logic [1:0]         lane_q [NUM_OBS];
    logic [1:0]         lane_n [NUM_OBS];
    logic [1:0]         type_q [NUM_OBS];
    logic [1:0]         type_n [NUM_OBS];
    logic [NUM_OBS-1:0] act_q, act_n, retired, free_pre, spawn_sel;
    logic               flick_q, step_q, passed_q;
    logic               play, clr, step_now, do_spawn;
    logic [1:0]         new_lane;

    assign play     = (game_state == 2'b01);
    assign clr      = reset || (game_state == 2'b00);
    assign step_now = play && (tick_cnt == period - 16'd1);

`ifdef OBS_SPEEDUP_EN
    localparam int RC_W = $clog2(LEVEL_STEP + NUM_OBS + 1);

    logic [2:0]      level_q;
    logic [RC_W-1:0] ret_cnt, ret_sum;
    logic [15:0]     dec_amt;

    assign dec_amt = 16'(level_q) * 16'(PERIOD_DEC);

    // max(MIN_PERIOD, BASE_PERIOD - dec) without letting the subtraction wrap
    always_comb begin
        if (dec_amt < 16'(BASE_PERIOD) && (16'(BASE_PERIOD) - dec_amt) > 16'(MIN_PERIOD))
            period = 16'(BASE_PERIOD) - dec_amt;
        else
            period = 16'(MIN_PERIOD);
    end

    always_comb begin
        ret_sum = ret_cnt;
        for (int i = 0; i < NUM_OBS; i++)
            ret_sum = ret_sum + RC_W'(retired[i]);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            level_q <= '0;
            ret_cnt <= '0;
        end else if (step_now) begin
            if (ret_sum >= RC_W'(LEVEL_STEP)) begin
                ret_cnt <= ret_sum - RC_W'(LEVEL_STEP);
                if (level_q < 3'(MAX_LEVEL))
                    level_q <= level_q + 3'd1;
            end else begin
                ret_cnt <= ret_sum;
            end
        end
    end

    assign level = level_q;
`else
    assign period = 16'(BASE_PERIOD);
    assign level  = '0;
`endif

    // Lane 3 does not exist on screen; fold it onto the middle lane.
    assign new_lane  = (lfsr[1:0] == 2'b11) ? 2'b01 : lfsr[1:0];
    assign free_pre  = ~act_q;
    assign spawn_sel = free_pre & (~free_pre + NUM_OBS'(1));
    assign gap_inc   = (gap_cnt >= gap_tgt) ? gap_tgt : gap_cnt + 16'd1;
    assign do_spawn  = (gap_inc == gap_tgt) && (|free_pre);

    always_comb begin
        act_n   = act_q;
        retired = '0;
        gap_n   = gap_inc;
        tgt_n   = gap_tgt;
        for (int i = 0; i < NUM_OBS; i++) begin
            x_n[i]    = x_q[i];
            lane_n[i] = lane_q[i];
            type_n[i] = type_q[i];
            if (act_q[i]) begin
                if (x_q[i] == '0) begin
                    retired[i] = 1'b1;
                    act_n[i]   = 1'b0;
                    x_n[i]     = SPAWN_XV;
                end else begin
                    x_n[i] = x_q[i] - X_W'(1);
                end
            end
            if (do_spawn && spawn_sel[i]) begin
                act_n[i]  = 1'b1;
                x_n[i]    = SPAWN_XV;
                lane_n[i] = new_lane;
                type_n[i] = lfsr[3:2];
            end
        end
        if (do_spawn) begin
            gap_n = '0;
            tgt_n = MIN_GAP16 + 16'(lfsr[4 +: GAP_RAND_W]);
        end
    end

    // The LFSR free-runs through idle and pause so spawn patterns depend on player timing.
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            tick_cnt <= '0;
            gap_cnt  <= '0;
            gap_tgt  <= MIN_GAP16;
            act_q    <= '0;
            flick_q  <= 1'b0;
            step_q   <= 1'b0;
            passed_q <= 1'b0;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i]    <= SPAWN_XV;
                lane_q[i] <= 2'b00;
                type_q[i] <= 2'b00;
            end
        end else if (step_now) begin
            tick_cnt <= '0;
            step_q   <= 1'b1;
            passed_q <= |retired;
            flick_q  <= ~flick_q;
            gap_cnt  <= gap_n;
            gap_tgt  <= tgt_n;
            act_q    <= act_n;
            for (int i = 0; i < NUM_OBS; i++) begin
                x_q[i]    <= x_n[i];
                lane_q[i] <= lane_n[i];
                type_q[i] <= type_n[i];
            end
        end else begin
            step_q   <= 1'b0;
            passed_q <= 1'b0;
            if (play)
                tick_cnt <= tick_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
        assign obs_x[g*X_W +: X_W] = x_q[g];
        assign obs_lane[g*2 +: 2]  = lane_q[g];
        assign obs_type[g*2 +: 2]  = type_q[g];
    end

    assign obs_active = act_q;
    assign flick      = flick_q;
    assign step       = step_q;
    assign passed     = passed_q;

endmodule
